// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 1-bit CPU execution controller.
// Holds the state encoding used by the run/halt/step FSM.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        HALT = 3'd0,
        RUN  = 3'd1,
        STEP = 3'd2,
        SKIP = 3'd3,
        BRK  = 3'd4
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled clock edges, sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller with one fetch-address breakpoint.
// Gates the CPU register enable and counts executed cycles.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_req,
    input  logic                halt_req,
    input  logic                step_req,
    input  logic                bp_en,
    input  logic [ADDR_W-1:0]   bp_addr,
    input  logic [ADDR_W-1:0]   pc,
    output logic                cpu_en,
    output logic                halted,
    output logic                bp_hit,
    output logic [STATE_W-1:0]  state,
    output logic [CNT_W-1:0]    cycle_cnt
);

    state_e r_state;
    state_e w_next;
    logic   r_step_q;
    logic   w_step_edge;
    logic   w_bp_match;
    logic   w_cpu_en;

    assign w_step_edge = step_req & ~r_step_q;
    assign w_bp_match  = bp_en & (pc == bp_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= HALT;
            r_step_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_q <= step_req;
        end
    end

    // Next state and enable decode; halt_req wins, then run_req, then a step edge.
    always_comb begin
        w_next   = r_state;
        w_cpu_en = 1'b0;
        case (r_state)
            HALT, BRK: begin
                if (halt_req)         w_next = HALT;
                else if (run_req)     w_next = SKIP;
                else if (w_step_edge) w_next = STEP;
            end
            SKIP: begin
                w_cpu_en = ~halt_req;
                w_next   = halt_req ? HALT : RUN;
            end
            RUN: begin
                w_cpu_en = ~halt_req & ~w_bp_match;
                if (halt_req)        w_next = HALT;
                else if (w_bp_match) w_next = BRK;
            end
            STEP: begin
                w_cpu_en = 1'b1;
                w_next   = HALT;
            end
            default: begin
                w_next = HALT;
            end
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_cpu_en),
        .cnt   (cycle_cnt)
    );

    assign cpu_en = w_cpu_en;
    assign state  = r_state;
    assign halted = (r_state == HALT) || (r_state == BRK);
    assign bp_hit = (r_state == BRK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a reference model feeding an expected-value queue.
// Bench CPU advances pc by one on every edge where cpu_en is high.
module tb_cpu_run_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [2:0]       st;
        logic             en;
        logic             hl;
        logic             bp;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic              clk;
    logic              reset;
    logic              run_req;
    logic              halt_req;
    logic              step_req;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] pc;
    logic              cpu_en;
    logic              halted;
    logic              bp_hit;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;

    int checks;
    int errors;

    obs_t q_exp[$];

    // Reference model state
    logic [2:0]        m_state;
    logic              m_stepq;
    logic [CNT_W-1:0]  m_cnt;
    logic [ADDR_W-1:0] m_pc;

    cpu_run_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t sample();
        obs_t o;
        o.st  = state;
        o.en  = cpu_en;
        o.hl  = halted;
        o.bp  = bp_hit;
        o.cnt = cycle_cnt;
        return o;
    endfunction

    // Drive one cycle at the falling edge, push the model's expectation, advance the model.
    task automatic drive(input logic run, input logic halt, input logic step);
        obs_t       e;
        logic       edge_s;
        logic       bpm;
        logic       en;
        logic [2:0] nxt;
        @(negedge clk);
        run_req  = run;
        halt_req = halt;
        step_req = step;
        pc       = m_pc;
        edge_s   = step && !m_stepq;
        bpm      = bp_en && (m_pc == bp_addr);
        en       = 1'b0;
        nxt      = m_state;
        if (m_state == 3'd0 || m_state == 3'd4) begin
            if (halt)        nxt = 3'd0;
            else if (run)    nxt = 3'd3;
            else if (edge_s) nxt = 3'd2;
        end else if (m_state == 3'd3) begin
            en  = !halt;
            nxt = halt ? 3'd0 : 3'd1;
        end else if (m_state == 3'd1) begin
            en  = !halt && !bpm;
            nxt = halt ? 3'd0 : (bpm ? 3'd4 : 3'd1);
        end else if (m_state == 3'd2) begin
            en  = 1'b1;
            nxt = 3'd0;
        end
        e.st  = m_state;
        e.en  = en;
        e.hl  = (m_state == 3'd0) || (m_state == 3'd4);
        e.bp  = (m_state == 3'd4);
        e.cnt = m_cnt;
        q_exp.push_back(e);
        if (en && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        if (en) m_pc = m_pc + 4'd1;
        m_stepq = step;
        m_state = nxt;
        #2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        m_state  = 3'd0;
        m_stepq  = 1'b0;
        m_cnt    = '0;
        m_pc     = '0;
        pc       = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        bp_en   = 1'b0;
        bp_addr = '0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e = q_exp.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_pre cyc%0d got %h exp %h", i, o, e);
            end
        end
        // Mid-RUN: assert reset away from the clock edge and check without an edge
        reset = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b exp 0", cpu_en); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %b exp 1", halted); end
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++;
        if (cycle_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cycle_cnt); end
        apply_reset();
        drive(1'b0, 1'b0, 1'b0);
        e = q_exp.pop_front();
        o = sample();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_post got %h exp %h", o, e); end
    endtask

    task automatic test_run_halt();
        obs_t e;
        obs_t o;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive((i < 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0);
            e = q_exp.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_halt cyc%0d got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (cycle_cnt !== 4'd5 || halted !== 1'b1) begin
            errors++;
            $display("FAIL run_halt_final cnt %0d halted %b exp cnt 5 halted 1", cycle_cnt, halted);
        end
    endtask

    task automatic test_step();
        obs_t e;
        obs_t o;
        int   pulses;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, (i % 3 == 0) ? 1'b1 : 1'b0);
            e = q_exp.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL step_pulse cyc%0d got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (cycle_cnt !== 4'd3) begin errors++; $display("FAIL step_cnt got %0d exp 3", cycle_cnt); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, (i < 10) ? 1'b1 : 1'b0);
            e = q_exp.pop_front();
            o = sample();
            if (cpu_en === 1'b1) pulses++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL step_held cyc%0d got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (pulses != 1 || cycle_cnt !== 4'd4) begin
            errors++;
            $display("FAIL step_held_once pulses %0d cnt %0d exp pulses 1 cnt 4", pulses, cycle_cnt);
        end
    endtask

    task automatic test_breakpoint();
        obs_t e;
        obs_t o;
        bp_en   = 1'b1;
        bp_addr = 4'h3;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive((i == 5 || i == 16) ? 1'b0 : 1'b1, (i == 16) ? 1'b1 : 1'b0, 1'b0);
            e = q_exp.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bp cyc%0d got %h exp %h", i, o, e);
            end
            if (i == 4) begin
                checks++;
                if (cpu_en !== 1'b0 || pc !== 4'h3) begin
                    errors++;
                    $display("FAIL bp_match_en got en %b pc %h exp en 0 pc 3", cpu_en, pc);
                end
            end
            if (i == 5) begin
                checks++;
                if (state !== 3'd4 || bp_hit !== 1'b1 || pc !== 4'h3) begin
                    errors++;
                    $display("FAIL bp_brk got st %0d hit %b pc %h exp st 4 hit 1 pc 3", state, bp_hit, pc);
                end
            end
            if (i == 15) begin
                checks++;
                if (state !== 3'd1 || cpu_en !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_resume got st %0d en %b exp st 1 en 1", state, cpu_en);
                end
            end
        end
        bp_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        obs_t e;
        obs_t o;
        bp_en   = 1'b1;
        bp_addr = 4'h2;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       drive(1'b1, 1'b1, 1'b1);
                1:       drive(1'b0, 1'b0, 1'b0);
                2, 3, 4,
                5:       drive(1'b1, 1'b0, 1'b0);
                6:       drive(1'b0, 1'b0, 1'b0);
                7:       drive(1'b1, 1'b0, 1'b1);
                default: drive(1'b0, 1'b0, 1'b0);
            endcase
            e = q_exp.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simul cyc%0d got %h exp %h", i, o, e);
            end
            if (i == 1) begin
                checks++;
                if (state !== 3'd0 || cycle_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL simul_all_halt got st %0d cnt %0d exp st 0 cnt 0", state, cycle_cnt);
                end
            end
            if (i == 8) begin
                checks++;
                if (state !== 3'd3 || cpu_en !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_brk_skip got st %0d en %b exp st 3 en 1", state, cpu_en);
                end
            end
        end
        bp_en = 1'b0;
    endtask

    task automatic test_saturation();
        obs_t e;
        obs_t o;
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            drive((i < 21) ? 1'b1 : 1'b0, (i == 21) ? 1'b1 : 1'b0, 1'b0);
            e = q_exp.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sat cyc%0d got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (cycle_cnt !== 4'hF) begin errors++; $display("FAIL sat_final got %h exp f", cycle_cnt); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = '0;
        pc       = '0;
        m_state  = 3'd0;
        m_stepq  = 1'b0;
        m_cnt    = '0;
        m_pc     = '0;
        test_reset();
        test_run_halt();
        test_step();
        test_breakpoint();
        test_simultaneous();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
